bt_uart_rx: RTL and testbench

UART receiver for the Bluetooth (HC-05) serial link: the receive-side counterpart of the existing transmitter. It synchronises the module's TX line, detects start bits, samples each bit at mid-bit, checks parity and stop, and holds the received byte in a one-deep output register. A valid/acknowledge handshake hands the byte to the game logic. Frames are start + 8 data bits (LSB first) + optional parity + 1 stop.

---
 rtl/bt_uart_rx.sv | 139 +++++++++++++
 tb/tb_bt_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bt_uart_rx.sv
// UART receiver for the HC-05 Bluetooth link: 2-flop synchroniser, mid-bit sampling,
// optional parity, single stop bit, one-deep output register with valid/ack handshake.
module bt_uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ack,
    output logic       done,
    output logic       busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             par_bad;
    logic             rx_meta, rx_s, rx_d;
    logic             par_err_now;
    logic             frame_good;

    // rx_d is the previous rx_s, used only to find the falling edge of the start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign par_err_now = PARITY_EN && par_bad;
    assign frame_good  = rx_s && !par_err_now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done <= 1'b0;
            // NOTE: the ack clear is written before the FSM so a same-cycle load below overrides it.
            if (ack) valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        par_bad <= ((^shift) ^ rx_s) != PARITY_ODD;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        frame_err  <= !rx_s;
                        parity_err <= par_err_now;
                        if (frame_good && (!valid || ack)) begin
                            dout    <= shift;
                            valid   <= 1'b1;
                            overrun <= 1'b0;
                        end else begin
                            overrun <= frame_good;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed bench for bt_uart_rx: one even-parity instance for the main sequence,
// plus a no-parity and an odd-parity instance for the variants.
module tb_bt_uart_rx;

    localparam int CPB = 16;

    logic TB_clk = 1'b0;
    logic rst_n;
    logic rx_a, rx_b, rx_c;
    logic ack_a, ack_b, ack_c;
    logic [7:0] dout_a, dout_b, dout_c;
    logic valid_a, valid_b, valid_c;
    logic done_a, done_b, done_c;
    logic busy_a, busy_b, busy_c;
    logic pe_a, pe_b, pe_c;
    logic fe_a, fe_b, fe_c;
    logic ov_a, ov_b, ov_c;

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc = 0;
    int   n_done_a = 0;
    int   n_busy_a = 0;
    int   t_busy_b = 0;
    int   t_done_b = 0;
    logic busy_b_q = 1'b0;

    int snap_done, snap_busy;

    always #5 TB_clk = ~TB_clk;

    bt_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_a (
        .clk(TB_clk), .rst_n(rst_n), .Rx(rx_a), .dout(dout_a), .valid(valid_a), .ack(ack_a),
        .done(done_a), .busy(busy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a)
    );

    bt_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_b (
        .clk(TB_clk), .rst_n(rst_n), .Rx(rx_b), .dout(dout_b), .valid(valid_b), .ack(ack_b),
        .done(done_b), .busy(busy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b)
    );

    bt_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_c (
        .clk(TB_clk), .rst_n(rst_n), .Rx(rx_c), .dout(dout_c), .valid(valid_c), .ack(ack_c),
        .done(done_c), .busy(busy_c), .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c)
    );

    // Event monitor on the falling edge, away from the DUT's active edge.
    always @(negedge TB_clk) begin
        cyc      <= cyc + 1;
        busy_b_q <= busy_b;
        if (done_a) n_done_a <= n_done_a + 1;
        if (busy_a) n_busy_a <= n_busy_a + 1;
        if (busy_b && !busy_b_q) t_busy_b <= cyc;
        if (done_b) t_done_b <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Drives one frame starting at a falling edge; ack_stop raises ack_a on the
    // cycle whose rising edge takes the stop-bit sample.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic has_par,
                              input logic par, input logic stop, input logic ack_stop);
        set_rx(sel, 1'b0);
        repeat (CPB) @(negedge TB_clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, data[i]);
            repeat (CPB) @(negedge TB_clk);
        end
        if (has_par) begin
            set_rx(sel, par);
            repeat (CPB) @(negedge TB_clk);
        end
        set_rx(sel, stop);
        repeat (10) @(negedge TB_clk);
        ack_a = ack_stop;
        @(negedge TB_clk);
        ack_a = 1'b0;
        repeat (CPB - 11) @(negedge TB_clk);
        set_rx(sel, 1'b1);
    endtask

    task automatic pulse_ack;
        ack_a = 1'b1;
        @(negedge TB_clk);
        ack_a = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_a  = 1'b1; rx_b  = 1'b1; rx_c  = 1'b1;
        ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
        repeat (3) @(negedge TB_clk);
        rst_n = 1'b1;

        // Reset and idle line
        check("rst_dout",  dout_a,  8'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_done",  done_a,  1'b0);
        check("rst_busy",  busy_a,  1'b0);
        snap_busy = n_busy_a;
        snap_done = n_done_a;
        repeat (200) @(negedge TB_clk);
        check("idle_busy_cycles", n_busy_a - snap_busy, 0);
        check("idle_done_count",  n_done_a - snap_done, 0);
        check("idle_valid", valid_a, 1'b0);
        check("idle_flags", {pe_a, fe_a, ov_a}, 3'b000);

        // Single good frame, then ack
        snap_done = n_done_a;
        send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        check("a5_done_count", n_done_a - snap_done, 1);
        check("a5_dout",  dout_a,  8'hA5);
        check("a5_valid", valid_a, 1'b1);
        check("a5_flags", {pe_a, fe_a, ov_a}, 3'b000);
        pulse_ack();
        check("a5_ack_valid", valid_a, 1'b0);
        check("a5_ack_dout",  dout_a,  8'hA5);

        // Back-to-back frames without ack
        snap_done = n_done_a;
        send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
        check("b2b_done_count", n_done_a - snap_done, 2);
        check("b2b_dout",    dout_a,  8'h3C);
        check("b2b_overrun", ov_a,    1'b1);
        check("b2b_valid",   valid_a, 1'b1);
        pulse_ack();
        check("b2b_ack_valid",  valid_a, 1'b0);
        check("b2b_ov_sticky",  ov_a,    1'b1);

        // Parity error: 0x01 needs parity 1 for even parity
        repeat (5) @(negedge TB_clk);
        send_frame(0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        check("perr_pe",    pe_a,    1'b1);
        check("perr_fe",    fe_a,    1'b0);
        check("perr_valid", valid_a, 1'b0);
        check("perr_dout",  dout_a,  8'h3C);

        // Framing error
        repeat (5) @(negedge TB_clk);
        send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ferr_fe",    fe_a,    1'b1);
        check("ferr_pe",    pe_a,    1'b0);
        check("ferr_valid", valid_a, 1'b0);

        // Good frame clears the sticky flags
        repeat (20) @(negedge TB_clk);
        send_frame(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        check("clr_flags", {pe_a, fe_a}, 2'b00);
        check("clr_valid", valid_a, 1'b1);
        check("clr_dout",  dout_a,  8'h00);
        pulse_ack();

        // Glitch: 5-cycle low pulse is rejected after half a bit
        repeat (5) @(negedge TB_clk);
        snap_done = n_done_a;
        snap_busy = n_busy_a;
        rx_a = 1'b0;
        repeat (5) @(negedge TB_clk);
        rx_a = 1'b1;
        repeat (30) @(negedge TB_clk);
        check("glitch_done_count", n_done_a - snap_done, 0);
        check("glitch_busy_cycles", n_busy_a - snap_busy, CPB / 2);
        check("glitch_busy", busy_a, 1'b0);
        check("glitch_valid", valid_a, 1'b0);

        // Load a nonzero byte, then abort a frame with reset at data bit 4
        send_frame(0, 8'h96, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_abort_dout", dout_a, 8'h96);
        repeat (5) @(negedge TB_clk);
        snap_done = n_done_a;
        rx_a = 1'b0;
        repeat (CPB) @(negedge TB_clk);
        for (int i = 0; i < 5; i++) begin
            rx_a = i[0];
            repeat (i == 4 ? CPB / 2 : CPB) @(negedge TB_clk);
        end
        check("abort_busy_before", busy_a, 1'b1);
        rst_n = 1'b0;
        @(negedge TB_clk);
        check("abort_dout",  dout_a,  8'h00);
        check("abort_valid", valid_a, 1'b0);
        check("abort_busy",  busy_a,  1'b0);
        check("abort_done",  done_a,  1'b0);
        rst_n = 1'b1;
        rx_a  = 1'b1;
        repeat (20) @(negedge TB_clk);
        check("abort_no_done", n_done_a - snap_done, 0);
        send_frame(0, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0);
        check("post_abort_dout",  dout_a,  8'h7E);
        check("post_abort_valid", valid_a, 1'b1);
        check("post_abort_flags", {pe_a, fe_a, ov_a}, 3'b000);

        // ack coincides with a load: load wins
        repeat (5) @(negedge TB_clk);
        send_frame(0, 8'h18, 1'b1, 1'b0, 1'b1, 1'b1);
        check("ackload_valid",   valid_a, 1'b1);
        check("ackload_dout",    dout_a,  8'h18);
        check("ackload_overrun", ov_a,    1'b0);

        // No-parity variant: done 9.5 bit times after the start edge
        send_frame(1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        check("nopar_dout",  dout_b,  8'h81);
        check("nopar_valid", valid_b, 1'b1);
        check("nopar_pe",    pe_b,    1'b0);
        check("nopar_latency", t_done_b - t_busy_b, (CPB * 19) / 2);

        // Odd-parity variant: 0x01 with parity bit 0 is correct
        send_frame(2, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        check("odd_pe",    pe_c,    1'b0);
        check("odd_valid", valid_c, 1'b1);
        check("odd_dout",  dout_c,  8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
